i2c_master_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one I2C master between `N_REQ` command requesters. It accepts a single-byte command (address, data, direction) from the winning requester and launches it on the master with a one-cycle `run` pulse. It then tracks the transaction through to completion or timeout and returns a per-requester completion pulse with ACK/NACK/timeout status. It sits directly in front of the I2C master; the master's SCL/SDA pins are untouched.

---
 rtl/i2c_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 35 +++
 rtl/i2c_master_arbiter.sv | 118 +++++++++++
 tb/tb_i2c_master_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C master arbiter and its helpers.
package i2c_arb_pkg;

  localparam int unsigned I2C_ADDR_W = 8;
  localparam int unsigned I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester after `last` (wrapping) wins.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned   base;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    base  = 32'(last);
    any   = |req;
    // Offset N revisits `last` itself, so it ranks lowest.
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((base + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master between N_REQ requesters: round-robin grant, launch,
// completion/timeout tracking and a per-owner response pulse.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [I2C_ADDR_W*N_REQ-1:0] req_addr,
  input  logic [I2C_DATA_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]            req_wr_en,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic                        rsp_nack,
  output logic                        rsp_timeout,
  output logic                        m_run,
  output logic [I2C_ADDR_W-1:0]       m_addr,
  output logic [I2C_DATA_W-1:0]       m_data,
  output logic                        m_wr_en,
  input  logic                        m_busy,
  input  logic                        m_done,
  input  logic                        m_nack
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  arb_state_e            state;
  logic [IW-1:0]         owner;
  logic [IW-1:0]         last;
  logic [CW-1:0]         cnt;

  logic [N_REQ-1:0]      pick_grant;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic [I2C_ADDR_W-1:0] sel_addr;
  logic [I2C_DATA_W-1:0] sel_data;
  logic                  sel_wr_en;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .last  (last),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_addr  = req_addr[pick_idx*I2C_ADDR_W +: I2C_ADDR_W];
    sel_data  = req_data[pick_idx*I2C_DATA_W +: I2C_DATA_W];
    sel_wr_en = req_wr_en[pick_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      last        <= IW'(N_REQ - 1);
      cnt         <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b0;
      m_run       <= 1'b0;
      m_addr      <= '0;
      m_data      <= '0;
      m_wr_en     <= 1'b0;
    end else begin
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b0;
      m_run       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            owner     <= pick_idx;
            m_addr    <= sel_addr;
            m_data    <= sel_data;
            m_wr_en   <= sel_wr_en;
            req_ready <= pick_grant;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          m_run <= 1'b1;
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          // A done pulse on the expiry cycle takes priority over the timeout.
          if (m_done || cnt == CNT_MAX) begin
            rsp_valid   <= N_REQ'(1) << owner;
            rsp_nack    <= m_done & m_nack;
            rsp_timeout <= ~m_done;
            last        <= owner;
            m_addr      <= '0;
            m_data      <= '0;
            m_wr_en     <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (state == WAIT_BUSY && m_busy) state <= WAIT_DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with N_REQ=4, TIMEOUT=32; the bench plays the master.
module tb_i2c_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_wr_en;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic        rsp_nack;
  logic        rsp_timeout;
  logic        m_run;
  logic [7:0]  m_addr;
  logic [7:0]  m_data;
  logic        m_wr_en;
  logic        m_busy;
  logic        m_done;
  logic        m_nack;

  int n_tests = 0;
  int n_fail  = 0;

  i2c_master_arbiter #(
    .N_REQ   (4),
    .TIMEOUT (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_wr_en   (req_wr_en),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_nack    (rsp_nack),
    .rsp_timeout (rsp_timeout),
    .m_run       (m_run),
    .m_addr      (m_addr),
    .m_data      (m_data),
    .m_wr_en     (m_wr_en),
    .m_busy      (m_busy),
    .m_done      (m_done),
    .m_nack      (m_nack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag, input logic [31:0] exp);
    int k;
    k = 0;
    while (req_ready == 4'b0 && k < 10) begin
      tick();
      k++;
    end
    chk(tag, 32'(req_ready), exp);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_wr_en = '0;
    m_busy    = 1'b0;
    m_done    = 1'b0;
    m_nack    = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk("rst_run", 32'(m_run), 0);
    chk("rst_addr", 32'(m_addr), 0);
    rst = 1'b0;
    tick();

    // Fairness: everyone valid, requester i has address 0x10+i.
    req_valid = 4'hF;
    req_addr  = 32'h1312_1110;
    req_data  = 32'h2322_2120;
    req_wr_en = 4'b0101;
    for (int n = 0; n < 8; n++) begin
      wait_ready("fair_grant", 32'(1 << (n % 4)));
      chk("fair_addr", 32'(m_addr), 32'(16 + n % 4));
      tick();
      chk("fair_run", 32'(m_run), 1);
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      chk("fair_rsp", 32'(rsp_valid), 32'(1 << (n % 4)));
    end
    req_valid = '0;
    tick();

    // Single request with a 20-cycle master.
    req_valid      = 4'b0001;
    req_addr[7:0]  = 8'hA0;
    req_data[7:0]  = 8'h5A;
    req_wr_en[0]   = 1'b1;
    tick();
    chk("single_ready", 32'(req_ready), 1);
    chk("single_run_early", 32'(m_run), 0);
    chk("single_addr", 32'(m_addr), 32'hA0);
    chk("single_data", 32'(m_data), 32'h5A);
    chk("single_wr", 32'(m_wr_en), 1);
    req_valid = '0;
    tick();
    chk("single_run", 32'(m_run), 1);
    chk("single_ready_off", 32'(req_ready), 0);
    m_busy = 1'b1;
    repeat (10) tick();
    chk("single_addr_held", 32'(m_addr), 32'hA0);
    chk("single_no_rsp", 32'(rsp_valid), 0);
    repeat (9) tick();
    m_done = 1'b1;
    m_busy = 1'b0;
    tick();
    m_done = 1'b0;
    chk("single_rsp", 32'(rsp_valid), 1);
    chk("single_nack", 32'(rsp_nack), 0);
    chk("single_to", 32'(rsp_timeout), 0);
    tick();
    chk("single_rsp_off", 32'(rsp_valid), 0);

    // NACK from requester 1.
    req_valid      = 4'b0010;
    req_addr[15:8] = 8'h42;
    tick();
    chk("nack_ready", 32'(req_ready), 2);
    req_valid = '0;
    tick();
    m_busy = 1'b1;
    repeat (3) tick();
    m_done = 1'b1;
    m_nack = 1'b1;
    m_busy = 1'b0;
    tick();
    m_done = 1'b0;
    m_nack = 1'b0;
    chk("nack_rsp", 32'(rsp_valid), 2);
    chk("nack_flag", 32'(rsp_nack), 1);
    chk("nack_to", 32'(rsp_timeout), 0);
    tick();
    chk("nack_rsp_off", 32'(rsp_valid), 0);
    chk("nack_flag_off", 32'(rsp_nack), 0);

    // Stray done while idle is ignored.
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    chk("idle_done", 32'(rsp_valid), 0);
    tick();

    // Timeout from requester 2: response exactly 32 cycles after m_run.
    req_valid = 4'b0100;
    tick();
    chk("to_ready", 32'(req_ready), 4);
    req_valid = '0;
    tick();
    chk("to_run", 32'(m_run), 1);
    m_busy = 1'b1;
    repeat (31) tick();
    chk("to_early", 32'(rsp_valid), 0);
    tick();
    chk("to_rsp", 32'(rsp_valid), 4);
    chk("to_flag", 32'(rsp_timeout), 1);
    chk("to_nack", 32'(rsp_nack), 0);
    m_busy = 1'b0;
    tick();
    chk("to_flag_off", 32'(rsp_timeout), 0);

    // Next request after a timeout, fast master completing in WAIT_BUSY.
    req_valid = 4'b1000;
    tick();
    chk("fast_ready", 32'(req_ready), 8);
    req_valid = '0;
    tick();
    chk("fast_run", 32'(m_run), 1);
    tick();
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    chk("fast_rsp", 32'(rsp_valid), 8);
    chk("fast_to", 32'(rsp_timeout), 0);
    chk("fast_nack", 32'(rsp_nack), 0);
    tick();

    // Done arrives on the expiry cycle: done wins.
    req_valid = 4'b0001;
    tick();
    chk("coll_ready", 32'(req_ready), 1);
    req_valid = '0;
    tick();
    chk("coll_run", 32'(m_run), 1);
    m_busy = 1'b1;
    repeat (31) tick();
    chk("coll_no_rsp", 32'(rsp_valid), 0);
    m_done = 1'b1;
    m_nack = 1'b1;
    m_busy = 1'b0;
    tick();
    m_done = 1'b0;
    m_nack = 1'b0;
    chk("coll_rsp", 32'(rsp_valid), 1);
    chk("coll_to", 32'(rsp_timeout), 0);
    chk("coll_nack", 32'(rsp_nack), 1);
    tick();

    // Reset while waiting for done.
    req_valid = 4'b0010;
    tick();
    chk("mrst_ready", 32'(req_ready), 2);
    req_valid = '0;
    tick();
    m_busy = 1'b1;
    repeat (5) tick();
    chk("mrst_addr_pre", 32'(m_addr), 32'h42);
    @(negedge clk);
    rst    = 1'b1;
    m_busy = 1'b0;
    #1;
    chk("mrst_addr", 32'(m_addr), 0);
    chk("mrst_data", 32'(m_data), 0);
    chk("mrst_wr", 32'(m_wr_en), 0);
    repeat (2) begin
      tick();
      chk("mrst_rsp", 32'(rsp_valid), 0);
    end
    rst       = 1'b0;
    req_valid = 4'b0011;
    tick();
    chk("mrst_grant0", 32'(req_ready), 1);
    chk("mrst_grant_addr", 32'(m_addr), 32'hA0);
    req_valid = '0;
    tick();
    chk("mrst_run", 32'(m_run), 1);
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    chk("mrst_rsp_done", 32'(rsp_valid), 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
